bus_mem_responder: RTL
======================

Name: bus_mem_responder

Overview:
- Target-side responder for the core's external bus, on the other end from the arbiter's initiator port (o_bus_en/o_wr_rd/o_wr_data/o_addr/o_size → i_ack/i_rd_data).
- Decodes an address window, services byte, half and word reads and writes into an internal word-organised RAM, and inserts a programmable number of wait states.
- Returns an ack pulse with right-justified, sign- or zero-extended read data.
- Serves as the main memory target for system-level simulation and FPGA builds.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first RAM word; must be 4-byte aligned.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles between request capture and ack; legal range 0..15.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_bus_en  in  1  request valid; initiator holds it high until it sees o_ack.
- i_wr_rd  in  1  1 = write, 0 = read.
- i_wr_data  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- i_addr  in  32  byte address.
- i_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- o_ack  out  1  one-cycle completion pulse.
- o_rd_data  out  32  read result; valid only while o_ack=1, otherwise 0.
- o_err  out  1  one-cycle pulse coincident with o_ack for misaligned or illegal-size accesses.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, o_ack=0, o_err=0, o_rd_data=0, o_busy=0, wait counter=0. RAM contents are not cleared.
- Hit: i_addr in [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). A miss is never claimed: no ack, no err, state stays IDLE, so another target may respond.
- IDLE: on i_bus_en=1 with a hit, latch addr, size, wr_rd and wr_data, load the counter with WAIT_STATES, and go to WAIT (or ACK if WAIT_STATES=0).
- WAIT: decrement the counter each cycle; at 0, go to ACK. Latched values are used throughout; input changes are ignored.
- ACK: o_ack=1 for exactly one cycle.
  - Write: RAM byte enables are updated on this edge.
  - Read: o_rd_data is driven from a registered RAM read performed on entry to ACK.
  - Then go to RELEASE.
- Latency: with capture at edge N, o_ack is high during the cycle after edge N+1+WAIT_STATES. For WAIT_STATES=0, ack is high in the cycle after the capture edge.
- RELEASE: wait for i_bus_en=0, then go to IDLE. This guarantees that a held i_bus_en is never counted as a second request. Minimum back-to-back spacing is one idle cycle of i_bus_en.
- Write lane placement, with word index = (addr-BASE_ADDR)>>2:
  - B/BU: byte lane addr[1:0] receives wr_data[7:0].
  - H/HU: lanes {addr[1],0} and {addr[1],1} receive wr_data[15:0].
  - W: all four lanes.
  - BU/HU writes behave as B/H.
- Read extraction: select the byte or half by addr[1:0]. B/H sign-extend to 32 bits; BU/HU zero-extend; W passes the word through.
- Errors: H/HU with addr[0]=1, W with addr[1:0]≠0, or an illegal size code produce:
  - no RAM write;
  - o_rd_data=0;
  - normal latency;
  - o_err=1 together with o_ack.
- Reset mid-transaction: the state machine returns to IDLE immediately and no ack is produced. A write is not committed unless its ACK edge completed before reset asserted.
- Read-after-write to the same address across two transactions returns the new data; there is no forwarding requirement inside a single transaction.

Test Plan:
- Reset, WAIT_STATES=1: release i_rst, write W 0xDEADBEEF @0x10, then read W @0x10 → o_ack high 3 cycles after the capture edge, o_rd_data=0xDEADBEEF, o_err=0.
- Byte/half lanes: write B 0x80 @0x21, then read B @0x21 → 0xFFFFFF80; read BU → 0x00000080; write H 0x1234 @0x22, read W @0x20 → 0x12348000 (assuming the word was previously 0).
- Misaligned: write W @0x13 data 0x11111111 → o_ack=1 and o_err=1 in the same cycle; a subsequent read W @0x10 is unchanged.
- Held enable: keep i_bus_en=1 for 10 cycles on a read @0x10 → exactly one o_ack pulse, o_busy stays high until i_bus_en falls, then returns to IDLE next cycle.
- Out of window with DEPTH_WORDS=1024, BASE=0: read @0x1000 → no o_ack and no o_err for 20 cycles, o_busy=0.
- Async reset mid-WAIT with WAIT_STATES=4: issue write @0x30, assert i_rst 2 cycles later → o_ack never pulses, o_busy=0 immediately, RAM @0x30 unchanged.

Source files
------------

// File: rtl/bus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bus_mem_responder_if : request/response bundle between the bus initiator
//                        and the memory responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bus_mem_responder_if;
    logic        i_bus_en;
    logic        i_wr_rd;
    logic [31:0] i_wr_data;
    logic [31:0] i_addr;
    logic [2:0]  i_size;
    logic        o_ack;
    logic [31:0] o_rd_data;
    logic        o_err;
    logic        o_busy;

    modport slave (
        input  i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size,
        output o_ack, o_rd_data, o_err, o_busy
    );

    modport master (
        output i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size,
        input  o_ack, o_rd_data, o_err, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder : windowed word-organised RAM target with byte/half/word
//                     access, programmable wait states and error reporting.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    bus_mem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lo_q, lo_d;
    logic [2:0]      size_q, size_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [31:0]     rd_word_q;

    logic [31:0]     w_off;
    logic            w_hit;
    logic            w_req_err;
    logic            w_commit;
    logic            w_enter_ack;
    logic [3:0]      w_be;
    logic [31:0]     w_lanes;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_rd_ext;

    logic [31:0]     mem [DEPTH_WORDS];

    assign w_off = bus.i_addr - BASE_ADDR;
    assign w_hit = (bus.i_addr >= BASE_ADDR) && ({1'b0, w_off} < WIN_BYTES);

    // Alignment and size legality are judged on the request as captured.
    always_comb begin
        w_req_err = 1'b0;
        case (bus.i_size)
            3'b000, 3'b100: w_req_err = 1'b0;
            3'b001, 3'b101: w_req_err = bus.i_addr[0];
            3'b010:         w_req_err = (bus.i_addr[1:0] != 2'b00);
            default:        w_req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        size_d    = size_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_bus_en && w_hit) begin
                    idx_d     = w_off[AW+1:2];
                    lo_d      = w_off[1:0];
                    size_d    = bus.i_size;
                    wr_d      = bus.i_wr_rd;
                    err_d     = w_req_err;
                    wr_data_d = bus.i_wr_data;
                    cnt_d     = WAIT_INIT;
                    state_d   = (WAIT_INIT == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            default: begin
                if (!bus.i_bus_en) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            lo_q      <= 2'b00;
            size_q    <= 3'b000;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wr_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lo_q      <= lo_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_lanes = wr_data_q;
        case (size_q[1:0])
            2'b00: begin
                w_be    = 4'b0001 << lo_q;
                w_lanes = {4{wr_data_q[7:0]}};
            end
            2'b01: begin
                w_be    = lo_q[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{wr_data_q[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = wr_data_q;
            end
        endcase
    end

    assign w_commit    = (state_q == S_ACK) && wr_q && !err_q;
    // idx_d covers the zero-wait case where ACK is entered straight from IDLE.
    assign w_enter_ack = (state_d == S_ACK);

    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem[idx_q][8*i +: 8] <= w_lanes[8*i +: 8];
            end
        end
        if (w_enter_ack) rd_word_q <= mem[idx_d];
    end

    always_comb begin
        w_byte   = rd_word_q[{lo_q, 3'b000} +: 8];
        w_half   = lo_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        w_rd_ext = 32'h0;
        case (size_q)
            3'b000:  w_rd_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_rd_ext = {24'h0, w_byte};
            3'b001:  w_rd_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_rd_ext = {16'h0, w_half};
            3'b010:  w_rd_ext = rd_word_q;
            default: w_rd_ext = 32'h0;
        endcase
    end

    assign bus.o_ack     = (state_q == S_ACK);
    assign bus.o_err     = (state_q == S_ACK) && err_q;
    assign bus.o_rd_data = ((state_q == S_ACK) && !err_q && !wr_q) ? w_rd_ext : 32'h0;
    assign bus.o_busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire
